// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit load port among NUM_REQ byte requesters.
// Each load opens a fixed frame window because the UART gives no busy indication.
module uart_tx_arbiter #(
  parameter int N            = 8,
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 160,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*N-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [N-1:0]         uart_data,
  output logic                 uart_up_data,
  output logic                 busy,
  output logic [GW-1:0]        last_grant
);

  // Handshake: a requester holds req high with stable req_data until it sees a
  // one-cycle ack; the byte is captured at that same edge, and the requester may
  // change data or drop req in the cycle after ack.

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [GW-1:0]   sel;
  logic            found;

  // First asserted request strictly after last_grant, wrapping around.
  always_comb begin
    logic [GW-1:0] idx;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ack          <= '0;
      uart_data    <= '0;
      uart_up_data <= 1'b0;
      busy         <= 1'b0;
      counter      <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
    end else begin
      ack          <= '0;
      uart_up_data <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            uart_data    <= req_data[int'(sel)*N +: N];
            ack[sel]     <= 1'b1;
            uart_up_data <= 1'b1;
            busy         <= 1'b1;
            last_grant   <= sel;
            counter      <= CW'(FRAME_CYCLES - 1);
            state        <= HOLD;
          end
        end
        HOLD: begin
          // uart_data stays put for the whole window; en and req are not looked at here.
          if (counter == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
